// File: rtl/pool_ctrl.sv
// Sequencer for the max-pool datapath: windows the element stream,
// drains the pool pipeline, and hands one maximum per window downstream.
// Optional fused ReLU on the captured result: define POOL_CTRL_RELU_EN.
module pool_ctrl #(
  parameter int NUM_WIDTH = 16,
  parameter int CNT_WIDTH = 8,
  parameter int POOL_LAT  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CNT_WIDTH-1:0] cfg_len,
  input  logic [NUM_WIDTH-1:0] up_data,
  input  logic                 up_valid,
  output logic                 up_ready,
  output logic [NUM_WIDTH-1:0] pool_data,
  output logic                 pool_valid,
  output logic                 pool_restart,
  input  logic [NUM_WIDTH-1:0] pool_result,
  output logic [NUM_WIDTH-1:0] dn_data,
  output logic                 dn_valid,
  input  logic                 dn_ready,
  output logic                 busy
);

  localparam int TW = (POOL_LAT > 1) ? $clog2(POOL_LAT) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(POOL_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic [CNT_WIDTH-1:0] r_len;
  logic [CNT_WIDTH-1:0] w_len_nxt;
  logic [TW-1:0]        r_tmr;
  logic [TW-1:0]        w_tmr_nxt;
  logic [NUM_WIDTH-1:0] r_dn_data;
  logic                 r_dn_valid;
  logic                 w_dv_nxt;
  logic                 w_cap;
  logic                 w_accept;
  logic [CNT_WIDTH-1:0] w_len_cfg;
  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic [NUM_WIDTH-1:0] w_cap_data;

  assign up_ready     = (r_state == S_IDLE) | (r_state == S_FILL);
  assign w_accept     = up_valid & up_ready;
  assign pool_valid   = w_accept;
  assign pool_data    = up_data;
  assign pool_restart = w_accept & (r_cnt == '0);
  assign busy         = (r_state != S_IDLE);
  assign dn_data      = r_dn_data;
  assign dn_valid     = r_dn_valid;

  assign w_len_cfg = (cfg_len == '0) ? CNT_WIDTH'(1) : cfg_len;
  assign w_cnt_inc = r_cnt + CNT_WIDTH'(1);

`ifdef POOL_CTRL_RELU_EN
  assign w_cap_data = pool_result[NUM_WIDTH-1] ? '0 : pool_result;
`else
  assign w_cap_data = pool_result;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state, counters, and result capture decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_tmr_nxt   = r_tmr;
    w_dv_nxt    = r_dn_valid;
    w_cap       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_len_nxt = w_len_cfg;
          w_tmr_nxt = '0;
          if (w_len_cfg == CNT_WIDTH'(1)) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_cnt_nxt   = CNT_WIDTH'(1);
            w_state_nxt = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (w_accept) begin
          if (w_cnt_inc == r_len) begin
            w_cnt_nxt   = '0;
            w_tmr_nxt   = '0;
            w_state_nxt = S_DRAIN;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      S_DRAIN: begin
        if (r_tmr == TMR_LAST) begin
          w_cap       = 1'b1;
          w_dv_nxt    = 1'b1;
          w_state_nxt = S_OUT;
        end else begin
          w_tmr_nxt = r_tmr + TW'(1);
        end
      end
      S_OUT: begin
        if (dn_ready) begin
          w_dv_nxt    = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers: window length, counters, and the held result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_len      <= CNT_WIDTH'(1);
      r_tmr      <= '0;
      r_dn_data  <= '0;
      r_dn_valid <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_len      <= w_len_nxt;
      r_tmr      <= w_tmr_nxt;
      r_dn_valid <= w_dv_nxt;
      if (w_cap) r_dn_data <= w_cap_data;
    end
  end

endmodule

// File: tb/tb_pool_ctrl.sv
// Bench for pool_ctrl: behavioural pool stub plus window-max reference.
// Directed scenarios followed by randomized windows.
module tb_pool_ctrl;

  localparam int NW  = 16;
  localparam int CW  = 8;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] cfg_len;
  logic [NW-1:0] up_data;
  logic          up_valid;
  logic          up_ready;
  logic [NW-1:0] pool_data;
  logic          pool_valid;
  logic          pool_restart;
  logic [NW-1:0] pool_result;
  logic [NW-1:0] dn_data;
  logic          dn_valid;
  logic          dn_ready;
  logic          busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_acc;

  always #5 clk = ~clk;

  pool_ctrl #(.NUM_WIDTH(NW), .CNT_WIDTH(CW), .POOL_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len),
    .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
    .pool_data(pool_data), .pool_valid(pool_valid),
    .pool_restart(pool_restart), .pool_result(pool_result),
    .dn_data(dn_data), .dn_valid(dn_valid), .dn_ready(dn_ready),
    .busy(busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Pool stub: running signed max, then a delay line so the max
  // including an element accepted in cycle t is visible in t+LAT.
  logic signed [NW-1:0] pm = '0;
  logic [NW-1:0] pd0 = '0, pd1 = '0, pd2 = '0;
  always @(posedge clk) begin
    if (pool_valid)
      pm <= (pool_restart || $signed(pool_data) > pm) ?
            $signed(pool_data) : pm;
    pd0 <= pm;
    pd1 <= pd0;
    pd2 <= pd1;
  end
  assign pool_result = pd2;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NW-1:0] ref_max(input logic [NW-1:0] q[$]);
    int m;
    m = $signed(q[0]);
    foreach (q[i]) if ($signed(q[i]) > m) m = $signed(q[i]);
`ifdef POOL_CTRL_RELU_EN
    if (m < 0) m = 0;
`endif
    return NW'(m);
  endfunction

  // Entered and left at posedge+1; drives one element then gap idles.
  task automatic send(input logic [NW-1:0] v, input logic exp_rst,
                      input int gap);
    up_valid = 1'b1;
    up_data  = v;
    @(negedge clk);
    check("up_ready_fill", 32'(up_ready), 32'd1);
    check("restart", 32'(pool_restart), 32'(exp_rst));
    last_acc = cyc;
    @(posedge clk); #1;
    up_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_win(input logic [NW-1:0] q[$], input int gmax);
    foreach (q[i])
      send(q[i], i == 0,
           (i == q.size() - 1) ? 0 : $urandom_range(gmax, 0));
  endtask

  // Waits for dn_valid, checks latency and value; if dn_ready is high
  // it also checks the handshake completes and input reopens.
  task automatic wait_result(input logic [NW-1:0] exp, input string tag);
    int n;
    bit got;
    got = 0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (dn_valid) begin got = 1; break; end
      if (up_ready) check("up_ready_drain", 32'(up_ready), 32'd0);
      @(posedge clk); #1;
    end
    if (!got) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_lat"}, 32'(cyc - last_acc), 32'(LAT + 1));
    check({tag, "_data"}, 32'(dn_data), 32'(exp));
    check({tag, "_ready_out"}, 32'(up_ready), 32'd0);
    if (dn_ready) begin
      @(posedge clk); #1;
      check({tag, "_dv_clr"}, 32'(dn_valid), 32'd0);
      check({tag, "_reopen"}, 32'(up_ready), 32'd1);
      check({tag, "_idle"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    logic [NW-1:0] q[$];
    logic [NW-1:0] held;
    int len;

    rst_n    = 1'b0;
    cfg_len  = CW'(4);
    up_data  = '0;
    up_valid = 1'b0;
    dn_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dv", 32'(dn_valid), 32'd0);
    check("rst_dd", 32'(dn_data), 32'd0);
    check("rst_ready", 32'(up_ready), 32'd1);
    @(posedge clk); #1;

    // 2x2 back-to-back
    q = '{16'd3, -16'sd2, 16'd7, 16'd5};
    send_win(q, 0);
    wait_result(ref_max(q), "w2x2");

    // Two windows; second must not see the first's maximum
    q = '{16'd1, 16'd2, 16'd3, 16'd4};
    send_win(q, 0);
    wait_result(ref_max(q), "win_a");
    q = '{-16'sd8, -16'sd6, -16'sd9, -16'sd7};
    send_win(q, 0);
    wait_result(ref_max(q), "win_b");

    // 3x3 with one idle cycle between elements
    cfg_len = CW'(9);
    q = {};
    for (int i = 0; i < 9; i++) q.push_back(NW'(i));
    foreach (q[i]) send(q[i], i == 0, (i == 8) ? 0 : 1);
    wait_result(ref_max(q), "gap9");

    // Backpressure for 10 cycles
    cfg_len  = CW'(4);
    dn_ready = 1'b0;
    q = '{16'd11, 16'd40, -16'sd3, 16'd12};
    send_win(q, 0);
    wait_result(ref_max(q), "bp");
    held = dn_data;
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_dv_hold", 32'(dn_valid), 32'd1);
      check("bp_dd_hold", 32'(dn_data), 32'(held));
      check("bp_ready_lo", 32'(up_ready), 32'd0);
    end
    dn_ready = 1'b1;
    @(negedge clk);
    check("bp_dv_at_rdy", 32'(dn_valid), 32'd1);
    @(posedge clk); #1;
    check("bp_dv_clr", 32'(dn_valid), 32'd0);
    check("bp_reopen", 32'(up_ready), 32'd1);

    // cfg_len 0 and 1: single-element windows
    for (int k = 0; k < 4; k++) begin
      cfg_len = CW'(k / 2);
      send(16'h7FFF, 1'b1, 0);
      wait_result(16'h7FFF, "len01");
    end

    // cfg_len changes mid-window are ignored
    cfg_len = CW'(4);
    q = '{16'd1, 16'd2, 16'd3, 16'd10};
    send(q[0], 1'b1, 0);
    cfg_len = CW'(2);
    send(q[1], 1'b0, 0);
    send(q[2], 1'b0, 0);
    send(q[3], 1'b0, 0);
    wait_result(ref_max(q), "cfgchg");

    // Reset after two of four elements
    cfg_len = CW'(4);
    send(16'd100, 1'b1, 0);
    send(16'd200, 1'b0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_dv", 32'(dn_valid), 32'd0);
    check("mrst_ready", 32'(up_ready), 32'd1);
    q = '{16'd9, 16'd1, 16'd1, 16'd1};
    send_win(q, 0);
    wait_result(ref_max(q), "mrst");

    // Random windows
    for (int w = 0; w < 12; w++) begin
      len = $urandom_range(9, 0);
      cfg_len = CW'(len);
      if (len == 0) len = 1;
      q = {};
      for (int i = 0; i < len; i++) q.push_back(NW'($urandom));
      send_win(q, 2);
      wait_result(ref_max(q), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pool_ctrl.md
Name: pool_ctrl

Overview:
Sequencer for the max-pool datapath (pool, NUM_WIDTH-wide, 4-cycle result latency).
- Accepts a valid/ready element stream and groups it into windows of cfg_len elements.
- Drives the pool's restart/valid/data inputs and waits out the pool pipeline.
- Captures one maximum per window and presents it downstream on a valid/ready handshake.
- Sits between the line/window buffer and the output writer of the pooling layer.

Parameters:
NUM_WIDTH, 16, element width (two's complement); must match the pool instance.
CNT_WIDTH, 8, width of cfg_len and the element counter.
POOL_LAT, 4, cycles from the last accepted element to a valid pool_result (fixed by pool; must be >= 1).

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cfg_len  in  CNT_WIDTH  elements per window (4 = 2x2, 9 = 3x3); latched on the first element of each window
up_data  in  NUM_WIDTH  input element
up_valid  in  1  input element valid
up_ready  out  1  controller can accept an element
pool_data  out  NUM_WIDTH  to pool up_data
pool_valid  out  1  to pool up_valid
pool_restart  out  1  to pool restart
pool_result  in  NUM_WIDTH  from pool dn_data
dn_data  out  NUM_WIDTH  window maximum
dn_valid  out  1  window maximum valid
dn_ready  in  1  downstream accepts the result
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock clk. rst_n is synchronous and active-low.
- Reset values: state=IDLE, counter=0, dn_valid=0, dn_data=0, busy=0. up_ready is 1 on the first cycle after reset.
- Reset mid-window or mid-drain aborts the window; no result is emitted. The pool's internal state is don't-care, because the next window starts with restart.
- Combinational outputs:
  - accept = up_valid & up_ready.
  - pool_valid = accept; pool_data = up_data.
  - pool_restart = accept & (counter==0).
  - up_ready = (state==IDLE) | (state==FILL).
- State IDLE: on accept, latch len = max(cfg_len, 1).
  - len==1: go to DRAIN.
  - otherwise: counter<=1, go to FILL.
- State FILL: on accept, counter++.
  - When counter+1==len: counter<=0, go to DRAIN.
  - up_valid gaps are allowed; counter holds.
- State DRAIN: timer counts POOL_LAT-1 cycles.
  - Let t be the cycle of the window's last accept. pool_result is captured into dn_data on the edge ending cycle t+POOL_LAT.
  - dn_valid=1 from cycle t+POOL_LAT+1; go to OUT.
- State OUT: hold dn_data and dn_valid stable until dn_ready.
  - On dn_valid & dn_ready: dn_valid<=0, go to IDLE. up_ready is high again the following cycle.
- Window overlap: none. up_ready=0 in DRAIN and OUT.
- Minimum window period: len + POOL_LAT + 1 cycles with dn_ready held high.
- cfg_len changes while busy are ignored until the next window starts.
- cfg_len==0 is treated as 1.
- Max comparison is signed (done in the pool). The controller performs no arithmetic on data.

Optional Feature:
POOL_CTRL_RELU_EN
- Defined: the captured value is clamped to 0 when pool_result[NUM_WIDTH-1]==1 (fused ReLU); dn_data is never negative.
- Undefined: pool_result is captured unmodified.
- Timing and handshake are identical in both builds.

Test Plan:
- 2x2 window: cfg_len=4, back-to-back up_data 3,-2,7,5, dn_ready=1.
  - pool_restart only with element 3.
  - dn_valid=1 exactly POOL_LAT+1 cycles after the last accept, dn_data=7.
  - up_ready low during DRAIN and OUT.
- Two windows, cfg_len=4: {1,2,3,4} then {-8,-6,-9,-7}.
  - Results 4 then -6; the second result is not contaminated by the first.
  - Without RELU_EN: dn_data=-6. With RELU_EN: dn_data=0.
- Gapped input: cfg_len=9, elements 0..8 (value 8 last), one idle cycle between each.
  - Result 8; counter holds across gaps.
  - The DRAIN interval is measured from the 9th accept.
- Backpressure: dn_ready=0 for 10 cycles after dn_valid.
  - dn_data and dn_valid stable; up_ready=0.
  - On the dn_ready cycle the result is accepted; up_ready=1 on the next cycle.
- Edge cases:
  - cfg_len=0 and cfg_len=1 with element 0x7FFF → each element forms its own window; result 0x7FFF.
  - cfg_len changed to 2 mid-window → current window still uses the latched 4.
- Reset mid-operation: rst_n=0 for one cycle after 2 of 4 elements, then a full window {9,1,1,1}.
  - No stale result is emitted; the next result is 9; busy=0 right after reset.
